// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns a load/store in MEM into one word-aligned
// bus transfer with a variable-latency req/ack handshake and stalls the pipe until it ends.
module load_store_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadData,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rd_q, rd_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        berr_q, berr_d;
  logic [2:0]  fn3_q, fn3_d;
  logic [1:0]  off_q, off_d;

  logic        ld_code, st_code, aligned, access, legal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, lane, ld_fmt;
  logic        is_idle;

  // Size/sign decode and natural-alignment check of the incoming access.
  always_comb begin
    ld_code = 1'b0;
    st_code = 1'b0;
    aligned = 1'b0;
    case (funct3M)
      3'b000: begin ld_code = 1'b1; st_code = 1'b1; aligned = 1'b1; end
      3'b001: begin ld_code = 1'b1; st_code = 1'b1; aligned = ~ALUResultM[0]; end
      3'b010: begin ld_code = 1'b1; st_code = 1'b1; aligned = ~|ALUResultM[1:0]; end
      3'b100: begin ld_code = 1'b1; aligned = 1'b1; end
      3'b101: begin ld_code = 1'b1; aligned = ~ALUResultM[0]; end
      default: ;
    endcase
  end

  assign access    = MemReadM | MemWriteM;
  assign legal     = (MemReadM ^ MemWriteM) & (MemReadM ? ld_code : st_code) & aligned;
  assign is_idle   = (state_q == S_IDLE);
  assign MisalignM = is_idle & access & ~legal;
  assign StallM    = (is_idle & legal) | (state_q == S_WAIT);

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin st_be = 4'b0001 << ALUResultM[1:0]; st_wdata = {4{WriteDataM[7:0]}}; end
      2'b01: begin st_be = 4'b0011 << ALUResultM[1:0]; st_wdata = {2{WriteDataM[15:0]}}; end
      default: ;
    endcase
  end

  // Lane select uses the offset captured at issue, since the bus returns whole words.
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (fn3_q)
      3'b000:  ld_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_fmt = {24'd0, lane[7:0]};
      3'b101:  ld_fmt = {16'd0, lane[15:0]};
      default: ld_fmt = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    berr_d  = 1'b0;
    fn3_d   = fn3_q;
    off_d   = off_q;
    case (state_q)
      S_IDLE: begin
        if (legal) begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
          req_d   = 1'b1;
          we_d    = MemWriteM;
          addr_d  = {ALUResultM[31:2], 2'b00};
          wdata_d = MemWriteM ? st_wdata : 32'd0;
          be_d    = MemWriteM ? st_be : 4'b1111;
          fn3_d   = funct3M;
          off_d   = ALUResultM[1:0];
        end else if (access) begin
          rd_d = 32'd0;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (!we_q) rd_d = ld_fmt;
        end else begin
          cnt_d = cnt_q + 8'd1;
          // Counter reaches the limit on this edge: abandon the transfer.
          if (cnt_q + 8'd1 == TO_LIMIT) begin
            state_d = S_DONE;
            req_d   = 1'b0;
            rd_d    = 32'd0;
            berr_d  = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      rd_q    <= 32'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      berr_q  <= 1'b0;
      fn3_q   <= 3'd0;
      off_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      berr_q  <= berr_d;
      fn3_q   <= fn3_d;
      off_q   <= off_d;
    end
  end

  assign ReadData  = rd_q;
  assign BusErrM   = berr_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model of stall/bus/readback
// behaviour, driven with directed cases then randomized accesses and latencies.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadData;
  logic        StallM, MisalignM, BusErrM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadData(ReadData), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  int stall_n = 0, req_n = 0, berr_n = 0;
  bit late_ack = 0;
  logic [31:0] cur_rd = 0;
  logic        exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic bit m_legal(bit r, bit w, bit [2:0] f, bit [31:0] a);
    int sz;
    bit ok;
    if (r == w) return 0;
    ok = r ? (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f inside {3'd0, 3'd1, 3'd2});
    sz = 1 << f[1:0];
    return ok && (a % sz == 0);
  endfunction

  function automatic bit [31:0] m_load(bit [2:0] f, bit [31:0] a, bit [31:0] d);
    longint v, nb;
    nb = 8 * (1 << f[1:0]);
    v  = longint'(d >> (8 * (a % 4)));
    if (nb < 32) begin
      v = v % (longint'(1) << nb);
      if (!f[2] && v >= (longint'(1) << (nb - 1))) v = v - (longint'(1) << nb);
    end
    return v[31:0];
  endfunction

  function automatic bit [3:0] m_be(bit [2:0] f, bit [31:0] a);
    int sz;
    sz = 1 << f[1:0];
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic bit [31:0] m_wdata(bit [2:0] f, bit [31:0] wd);
    if (f[1:0] == 2'd0) return {24'd0, wd[7:0]} * 32'h01010101;
    if (f[1:0] == 2'd1) return {16'd0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  // One pipeline cycle: drive inputs after the edge, compare on the falling edge.
  task automatic cyc(input bit r, input bit w, input bit [2:0] f, input bit [31:0] a,
                     input bit [31:0] wd, input bit ack, input bit [31:0] rdat,
                     input bit es, input bit er, input bit em, input bit eb,
                     input bit [31:0] erd);
    @(posedge clk); #1;
    MemReadM = r; MemWriteM = w; funct3M = f; ALUResultM = a; WriteDataM = wd;
    mem_ack = ack; mem_rdata = rdat;
    @(negedge clk);
    check("stall", 32'(StallM), 32'(es));
    check("req", 32'(mem_req), 32'(er));
    check("misalign", 32'(MisalignM), 32'(em));
    check("buserr", 32'(BusErrM), 32'(eb));
    check("readdata", ReadData, erd);
    if (er) begin
      check("we", 32'(mem_we), 32'(exp_we));
      check("addr", mem_addr, exp_addr);
      check("be", 32'(mem_be), 32'(exp_be));
      if (exp_we) check("wdata", mem_wdata, exp_wdata);
    end
    if (mem_req) begin
      cap_addr = mem_addr; cap_wdata = mem_wdata; cap_be = mem_be; cap_we = mem_we;
    end
    stall_n += int'(StallM);
    req_n   += int'(mem_req);
    berr_n  += int'(BusErrM);
  endtask

  task automatic gap(input bit ack);
    cyc(0, 0, 3'($urandom), $urandom, $urandom, ack, $urandom, 0, 0, 0, 0, cur_rd);
  endtask

  // lat = extra wait states before ack; lat >= TO means the memory never answers.
  task automatic run_txn(input bit r, input bit w, input bit [2:0] f, input bit [31:0] a,
                         input bit [31:0] wd, input bit [31:0] rdat, input int lat);
    bit to;
    int nw;
    bit [31:0] nrd;
    if (!m_legal(r, w, f, a)) begin
      cyc(r, w, f, a, wd, 1'($urandom), $urandom, 0, 0, r | w, 0, cur_rd);
      if (r | w) cur_rd = 0;
      return;
    end
    to  = (lat >= TO);
    nw  = to ? TO : lat + 1;
    nrd = to ? 32'd0 : (r ? m_load(f, a, rdat) : cur_rd);
    exp_we    = w;
    exp_addr  = a & ~32'd3;
    exp_be    = w ? m_be(f, a) : 4'hf;
    exp_wdata = m_wdata(f, wd);
    for (int c = 0; c <= nw + 1; c++) begin
      bit ak;
      ak = (c == nw && !to) ||
           ((c == 0 || c == nw + 1) && (late_ack || $urandom_range(0, 1) == 1));
      cyc(r, w, f, a, wd, ak, (c == nw) ? rdat : $urandom,
          c <= nw, c >= 1 && c <= nw, 0, (c == nw + 1) && to,
          (c == nw + 1) ? nrd : cur_rd);
    end
    cur_rd = nrd;
  endtask

  initial begin
    int s0, r0, b0;
    rst = 0; MemReadM = 0; MemWriteM = 0; funct3M = 0; ALUResultM = 0; WriteDataM = 0;
    mem_rdata = 0; mem_ack = 0;
    @(negedge clk);
    check("rst_readdata", ReadData, 0);
    check("rst_req", 32'(mem_req), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_be", 32'(mem_be), 0);
    check("rst_buserr", 32'(BusErrM), 0);
    check("rst_stall", 32'(StallM), 0);
    @(posedge clk); #1; rst = 1;

    s0 = stall_n; r0 = req_n;
    run_txn(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0);
    check("lw_lit", ReadData, 32'hDEADBEEF);
    check("lw_stall_cycles", stall_n - s0, 2);
    check("lw_req_cycles", req_n - r0, 1);
    run_txn(1, 0, 3'b000, 32'h103, 0, 32'h80FF1234, 1);
    check("lb_lit", ReadData, 32'hFFFFFF80);
    run_txn(1, 0, 3'b100, 32'h103, 0, 32'h80FF1234, 2);
    check("lbu_lit", ReadData, 32'h00000080);
    run_txn(0, 1, 3'b000, 32'h202, 32'h000000A5, 0, 0);
    check("sb_be_lit", 32'(cap_be), 32'h4);
    check("sb_wdata_lit", cap_wdata, 32'hA5A5A5A5);
    check("sb_addr_lit", cap_addr, 32'h200);
    check("sb_we_lit", 32'(cap_we), 1);
    run_txn(0, 1, 3'b001, 32'h202, 32'h00001234, 0, 1);
    check("sh_be_lit", 32'(cap_be), 32'hC);
    check("sh_wdata_lit", cap_wdata, 32'h12341234);
    check("st_keeps_rd", ReadData, 32'h00000080);

    r0 = req_n;
    run_txn(1, 0, 3'b010, 32'h101, 0, 0, 0);
    gap(0);
    check("mis_rd_lit", ReadData, 0);
    run_txn(1, 0, 3'b100, 32'h103, 0, 32'h80FF1234, 0);
    run_txn(1, 0, 3'b011, 32'h108, 0, 0, 0);
    gap(0);
    check("ill_rd_lit", ReadData, 0);
    check("mis_req_lit", req_n - r0, 1);

    run_txn(1, 0, 3'b010, 32'h100, 0, 32'h13572468, 0);
    s0 = stall_n; r0 = req_n; b0 = berr_n;
    late_ack = 1;
    run_txn(1, 0, 3'b010, 32'h300, 0, 32'hFFFFFFFF, TO);
    late_ack = 0;
    gap(1);
    check("to_req_cycles", req_n - r0, TO);
    check("to_stall_cycles", stall_n - s0, TO + 1);
    check("to_berr_cycles", berr_n - b0, 1);
    check("to_rd_lit", ReadData, 0);

    // Abort a load in its second WAIT cycle with an asynchronous reset.
    exp_we = 0; exp_addr = 32'h40; exp_be = 4'hf;
    cyc(1, 0, 3'b010, 32'h40, 0, 0, 0, 1, 0, 0, 0, cur_rd);
    cyc(1, 0, 3'b010, 32'h40, 0, 0, 0, 1, 1, 0, 0, cur_rd);
    @(posedge clk); #2;
    rst = 0; MemReadM = 0;
    #1;
    check("midrst_req", 32'(mem_req), 0);
    check("midrst_idle", 32'(StallM), 0);
    check("midrst_be", 32'(mem_be), 0);
    @(posedge clk); #1; rst = 1; cur_rd = 0;
    run_txn(1, 0, 3'b010, 32'h44, 0, 32'hCAFEF00D, 1);
    check("post_rst_lw", ReadData, 32'hCAFEF00D);

    for (int i = 0; i < 300; i++) begin
      bit r, w;
      bit [2:0] f;
      int k;
      k = $urandom_range(0, 9);
      r = (k == 0) || (k >= 2 && k <= 5);
      w = (k == 0) || (k >= 6);
      f = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(0, 2)) : 3'($urandom);
      run_txn(r, w, f, $urandom, $urandom, $urandom, $urandom_range(0, TO));
      if ($urandom_range(0, 3) == 0) gap(1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the 5-stage RV32I pipeline. It sits between the MEM pipeline register outputs and an external data memory with a variable-latency req/ack handshake. It converts `ALUResultM`/`WriteDataM`/`funct3M` into word-aligned bus transfers with byte enables, and returns sign- or zero-extended load data to the MEM/WB register. It stalls the pipeline until each access completes and flags misaligned or illegal accesses and bus timeouts.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum number of cycles in WAIT without `mem_ack` before a bus error is raised. Legal range is 1..255.

Ports:
- `clk`  in  1  pipeline clock; everything is rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `MemReadM`  in  1  load instruction is in MEM.
- `MemWriteM`  in  1  store instruction is in MEM.
- `funct3M`  in  3  load/store size and sign code.
- `ALUResultM`  in  32  byte address.
- `WriteDataM`  in  32  store source register value.
- `ReadData`  out  32  formatted load data, registered.
- `StallM`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; hold MEM/WB (insert bubble).
- `MisalignM`  out  1  combinational flag: misaligned or illegal access, no bus transfer issued.
- `BusErrM`  out  1  one-cycle pulse when a bus timeout occurs.
- `mem_req`  out  1  bus request, registered.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address, `{ALUResultM[31:2],2'b00}`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables.
- `mem_rdata`  in  32  read word, valid with `mem_ack`.
- `mem_ack`  in  1  transfer complete; only sampled in WAIT.

## Operation
- FSM states and transitions:
  - IDLE → WAIT when a legal access is seen.
  - WAIT → DONE on `mem_ack` or on timeout.
  - DONE → IDLE unconditionally. DONE never starts an access, because the instruction that just finished is still in MEM.
- Access decode:
  - Access = `MemReadM | MemWriteM`.
  - Both high is illegal.
  - Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. All other codes are illegal.
  - Stores: funct3 000 SB, 001 SH, 010 SW. All other codes are illegal.
- Alignment: halfword requires `addr[0]=0`; word requires `addr[1:0]=00`.
- Illegal or misaligned access in IDLE:
  - `MisalignM`=1, `StallM`=0.
  - No request is issued and the store is suppressed.
  - `ReadData` is loaded with 0 at the clock edge.
- Byte enables and write data:
  - SB: `mem_be=4'b0001<<addr[1:0]`, `mem_wdata` = byte replicated ×4.
  - SH: `mem_be=4'b0011<<addr[1:0]`, `mem_wdata` = halfword replicated ×2.
  - SW: `mem_be=4'b1111`.
  - Loads drive `mem_be=4'b1111` and `mem_we=0`.
- Bus outputs `mem_req/we/addr/wdata/be` are registered on the IDLE→WAIT edge and held stable throughout WAIT.
- Load formatting on ack: select the lane by `addr[1:0]`, then sign-extend (LB/LH) or zero-extend (LBU/LHU) into the `ReadData` register. Stores leave `ReadData` unchanged.
- Timeout:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the counter reaches `TIMEOUT`: drop `mem_req`, load `ReadData`=0, pulse `BusErrM`, go to DONE.
- `mem_ack` outside WAIT is ignored.

## Timing
- Reset values: state IDLE; `ReadData`=0; `mem_req`=0; `mem_we`=0; `mem_addr`=0; `mem_wdata`=0; `mem_be`=0; counter 0; `BusErrM`=0.
- Asserting `rst` mid-transfer drops `mem_req` immediately (asynchronous) and returns the FSM to IDLE.
- `StallM` = (IDLE & legal access) | WAIT. It is combinational and asserted in the same cycle the access first appears.
- Zero-wait-state memory (ack in the first WAIT cycle):
  - Cycle 0: access seen, stall asserted.
  - Cycle 1: `mem_req`=1, ack arrives.
  - Cycle 2: DONE, `StallM`=0, `ReadData` valid and captured by MEM/WB at the end of the cycle.
  - Result: 2 stall cycles per access.
- Each additional wait state adds one stall cycle.
- Timeout case: stall lasts `TIMEOUT`+1 cycles; `BusErrM` is high during the DONE cycle only.
- `mem_req` falls on the edge that enters DONE.
- Back-to-back accesses: the next access is evaluated in the IDLE cycle after DONE, giving a minimum of 3 cycles per access.

## Test plan
- **LW, zero-wait:** addr 0x100, `mem_rdata`=0xDEADBEEF with ack in cycle 1 → `StallM` high in cycles 0–1; `mem_req` high in cycle 1 only; `ReadData`=0xDEADBEEF in cycle 2.
- **LB/LBU at addr 0x103**, `mem_rdata`=0x80FF1234 → LB gives 0xFFFFFF80; LBU gives 0x00000080.
- **SB 0xA5 at 0x202** → `mem_be`=0100, `mem_wdata`=0xA5A5A5A5, `mem_addr`=0x200, `mem_we`=1. **SH 0x1234 at 0x202** → `mem_be`=1100.
- **Misaligned LW at 0x101, and funct3=011 load** → `MisalignM`=1, `StallM`=0, `mem_req` stays 0, `ReadData`=0 next cycle.
- **Timeout:** `TIMEOUT`=4, no ack → `mem_req` high for 4 cycles, then `BusErrM` pulses for 1 cycle with `ReadData`=0. A late ack arriving in DONE or IDLE is ignored.
- **Reset mid-WAIT:** `rst` low during cycle 2 of WAIT → `mem_req`=0 and state IDLE immediately. After release, an LW completes normally.
